// File: rtl/alu_exec_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_pkg
// Shared types for the ALU execution unit: the opcode encoding, the bit
// positions of the {N,Z,C,V} flags in out_flags, the control FSM states and a
// helper that classifies shift opcodes.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_exec_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_NOT = 4'd4,
      OP_XOR = 4'd5,
      OP_LSL = 4'd6,
      OP_LSR = 4'd7,
      OP_ASL = 4'd8,
      OP_ASR = 4'd9
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } exec_state_e;

   function automatic logic is_shift_op(input logic [3:0] op);
      logic r;
      case (op)
         OP_LSL, OP_LSR, OP_ASL, OP_ASR: r = 1'b1;
         default:                        r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// -----------------------------------------------------------------------------
// alu_shift_unit
// Shift datapath for alu_exec_unit.
//   SHIFT_ITER = 0 : combinational barrel shifter on a_i/amt_i (imm_* outputs).
//   SHIFT_ITER = 1 : one-bit-per-cycle shifter. load_i captures operand, amount
//                    and direction; every step_i cycle moves one bit and counts
//                    down. step_* shows the value after the current step and
//                    last_o marks the step that completes the shift. imm_*
//                    then only serves amount 0 (operand unchanged, C = 0).
// Ports: clk, rst (async, active high), load_i, step_i, op_i, a_i, amt_i,
//        imm_res_o, imm_cout_o, step_res_o, step_cout_o, last_o.
// -----------------------------------------------------------------------------
module alu_shift_unit
   import alu_exec_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SHIFT_ITER = 0,
   localparam int SW        = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [SW-1:0]    amt_i,
   output logic [WIDTH-1:0] imm_res_o,
   output logic             imm_cout_o,
   output logic [WIDTH-1:0] step_res_o,
   output logic             step_cout_o,
   output logic             last_o
);

   logic is_left_s;
   assign is_left_s = (op_i == OP_LSL) || (op_i == OP_ASL);

   if (SHIFT_ITER == 0) begin : g_barrel
      logic [WIDTH:0] ext_l_s;
      logic [WIDTH:0] ext_r_s;
      logic           unused_s;

      // Shift one bit wider than the operand: the extra bit is the last bit out
      always_comb begin
         ext_l_s = {1'b0, a_i} << amt_i;
         if (op_i == OP_ASR) begin
            ext_r_s = $unsigned($signed({a_i, 1'b0}) >>> amt_i);
         end else begin
            ext_r_s = {a_i, 1'b0} >> amt_i;
         end
         if (is_left_s) begin
            imm_res_o  = ext_l_s[WIDTH-1:0];
            imm_cout_o = ext_l_s[WIDTH];
         end else begin
            imm_res_o  = ext_r_s[WIDTH:1];
            imm_cout_o = ext_r_s[0];
         end
      end

      assign step_res_o  = '0;
      assign step_cout_o = 1'b0;
      assign last_o      = 1'b0;
      assign unused_s    = &{1'b0, clk, rst, load_i, step_i};
   end else begin : g_iter
      logic [WIDTH-1:0] val_q, val_d;
      logic [SW-1:0]    cnt_q, cnt_d;
      logic             left_q, left_d;
      logic             arith_q, arith_d;

      assign imm_res_o  = a_i;
      assign imm_cout_o = 1'b0;
      assign last_o     = (cnt_q == SW'(1));

      // Value after moving one more bit; ASR replicates the sign bit
      always_comb begin
         if (left_q) begin
            step_res_o  = {val_q[WIDTH-2:0], 1'b0};
            step_cout_o = val_q[WIDTH-1];
         end else begin
            step_res_o  = {arith_q & val_q[WIDTH-1], val_q[WIDTH-1:1]};
            step_cout_o = val_q[0];
         end
      end

      // Next state of the shift register and bit counter
      always_comb begin
         val_d   = val_q;
         cnt_d   = cnt_q;
         left_d  = left_q;
         arith_d = arith_q;
         if (load_i) begin
            val_d   = a_i;
            cnt_d   = amt_i;
            left_d  = is_left_s;
            arith_d = (op_i == OP_ASR);
         end else if (step_i) begin
            val_d = step_res_o;
            cnt_d = cnt_q - SW'(1);
         end else begin
            val_d = val_q;
            cnt_d = cnt_q;
         end
      end

      // Shift register and counter state
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            val_q   <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
         end else begin
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
         end
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Registered ALU stage between operand fetch and writeback. Executes ADD, SUB,
// AND, OR, NOT, XOR, LSL, LSR, ASL, ASR on WIDTH-bit operands and holds the
// result with {N,Z,C,V} flags behind valid/ready handshakes. SHIFT_ITER = 1
// swaps the barrel shifter for a one-bit-per-cycle shifter.
// Optional build macro ALU_EXEC_OPCOUNT_EN adds op_count (result handshakes,
// wrapping) and err_count (illegal-opcode results, saturating).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operation handshake; in_op, in_a, in_b captured on it
//   out_valid/out_ready   result handshake; out_result, out_flags, out_err
//   busy                  iterative shift in progress
//   op_count, err_count   (only with ALU_EXEC_OPCOUNT_EN)
// -----------------------------------------------------------------------------
module alu_exec_unit
   import alu_exec_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SHIFT_ITER = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic             out_err,
   output logic             busy
`ifdef ALU_EXEC_OPCOUNT_EN
   ,
   output logic [15:0]      op_count,
   output logic [7:0]       err_count
`endif
);

   localparam int SW     = $clog2(WIDTH);
   localparam int MSB    = WIDTH - 1;
   localparam bit ITER_EN = (SHIFT_ITER != 32'sd0);

   function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] res,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_N] = res[MSB];
      f[FLAG_Z] = (res == '0);
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

   exec_state_e      state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [3:0]       flags_q, flags_d;
   logic             err_q, err_d;
   logic [3:0]       op_q, op_d;
   logic             amsb_q, amsb_d;

   logic [WIDTH:0]   sum_s, diff_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_c_s, alu_v_s, alu_err_s;
   logic             accept_s, go_iter_s;
   logic [WIDTH-1:0] imm_res_s, step_res_s;
   logic             imm_cout_s, step_cout_s, sh_last_s;
   logic             step_v_s;

   assign in_ready  = !rst && ((state_q == ST_IDLE) ||
                               ((state_q == ST_HOLD) && out_ready));
   assign accept_s  = in_valid && in_ready;
   assign go_iter_s = ITER_EN && is_shift_op(in_op) && (in_b[SW-1:0] != '0);

   assign out_valid  = (state_q == ST_HOLD);
   assign busy       = (state_q == ST_SHIFT);
   assign out_result = res_q;
   assign out_flags  = flags_q;
   assign out_err    = err_q;

   alu_shift_unit #(
      .WIDTH      (WIDTH),
      .SHIFT_ITER (SHIFT_ITER)
   ) u_shift (
      .clk         (clk),
      .rst         (rst),
      .load_i      (accept_s && go_iter_s),
      .step_i      (state_q == ST_SHIFT),
      .op_i        (in_op),
      .a_i         (in_a),
      .amt_i       (in_b[SW-1:0]),
      .imm_res_o   (imm_res_s),
      .imm_cout_o  (imm_cout_s),
      .step_res_o  (step_res_s),
      .step_cout_o (step_cout_s),
      .last_o      (sh_last_s)
   );

   // Single-cycle result for every opcode offered on the input
   always_comb begin
      sum_s     = {1'b0, in_a} + {1'b0, in_b};
      diff_s    = {1'b0, in_a} - {1'b0, in_b};
      alu_res_s = '0;
      alu_c_s   = 1'b0;
      alu_v_s   = 1'b0;
      alu_err_s = 1'b0;
      case (in_op)
         OP_ADD: begin
            alu_res_s = sum_s[MSB:0];
            alu_c_s   = sum_s[WIDTH];
            alu_v_s   = (in_a[MSB] == in_b[MSB]) && (sum_s[MSB] != in_a[MSB]);
         end
         OP_SUB: begin
            alu_res_s = diff_s[MSB:0];
            alu_c_s   = !diff_s[WIDTH];   // no borrow means A >= B
            alu_v_s   = (in_a[MSB] != in_b[MSB]) && (diff_s[MSB] != in_a[MSB]);
         end
         OP_AND: alu_res_s = in_a & in_b;
         OP_OR:  alu_res_s = in_a | in_b;
         OP_NOT: alu_res_s = ~in_a;
         OP_XOR: alu_res_s = in_a ^ in_b;
         OP_LSL, OP_LSR, OP_ASR: begin
            alu_res_s = imm_res_s;
            alu_c_s   = imm_cout_s;
         end
         OP_ASL: begin
            alu_res_s = imm_res_s;
            alu_c_s   = imm_cout_s;
            alu_v_s   = imm_res_s[MSB] ^ in_a[MSB];
         end
         default: alu_err_s = 1'b1;
      endcase
   end

   // ASL overflow for the iterative path compares against the captured A sign
   always_comb begin
      if (op_q == OP_ASL) begin
         step_v_s = step_res_s[MSB] ^ amsb_q;
      end else begin
         step_v_s = 1'b0;
      end
   end

   // Control FSM next state and result register loads
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      flags_d = flags_q;
      err_d   = err_q;
      op_d    = op_q;
      amsb_d  = amsb_q;
      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (accept_s) begin
               op_d   = in_op;
               amsb_d = in_a[MSB];
               if (go_iter_s) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_HOLD;
                  res_d   = alu_res_s;
                  flags_d = pack_flags(alu_res_s, alu_c_s, alu_v_s);
                  err_d   = alu_err_s;
               end
            end else if ((state_q == ST_HOLD) && out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         ST_SHIFT: begin
            if (sh_last_s) begin
               state_d = ST_HOLD;
               res_d   = step_res_s;
               flags_d = pack_flags(step_res_s, step_cout_s, step_v_s);
               err_d   = 1'b0;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control FSM and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         flags_q <= 4'b0000;
         err_q   <= 1'b0;
         op_q    <= 4'd0;
         amsb_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         err_q   <= err_d;
         op_q    <= op_d;
         amsb_q  <= amsb_d;
      end
   end

`ifdef ALU_EXEC_OPCOUNT_EN
   logic [15:0] op_cnt_q;
   logic [7:0]  err_cnt_q;

   // Result handshake counters: total wraps, error count saturates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_cnt_q  <= 16'd0;
         err_cnt_q <= 8'd0;
      end else if (out_valid && out_ready) begin
         op_cnt_q <= op_cnt_q + 16'd1;
         if (err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign op_count  = op_cnt_q;
   assign err_count = err_cnt_q;
`endif

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised, registered successor to the 1-bit opcode result selector. Executes the same ten operations (ADD, SUB, AND, OR, NOT, XOR, LSL, LSR, ASL, ASR) on WIDTH-bit operands.
- Registers result plus NZCV flags behind valid/ready handshakes.
- Optional iterative 1-bit-per-cycle shifter for area-limited builds.
- Sits between decode/operand fetch and writeback in the microcontroller datapath.

Parameters:
- WIDTH, 8: operand/result width; power of two, >= 4.
- SHIFT_ITER, 0: 0 = single-cycle barrel shift; 1 = iterative shift, one bit per cycle.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit accepts an operation this cycle.
- in_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 XOR, 6 LSL, 7 LSR, 8 ASL, 9 ASR, 10-15 illegal.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B; shift amount is in_b[$clog2(WIDTH)-1:0].
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes result.
- out_result  output  WIDTH  registered result.
- out_flags  output  4  {N,Z,C,V}.
- out_err  output  1  illegal opcode reported with this result.
- busy  output  1  iterative shift in progress.

Behaviour:
- Reset: all outputs 0; in_ready is 1 once reset deasserts; FSM goes to IDLE.
- Accept condition: in_valid && in_ready. in_ready = (state==IDLE) || (state==HOLD && out_ready).
- FSM states are IDLE, SHIFT, HOLD.
  - IDLE or HOLD, on accept: non-shift op, barrel shift, or shift amount 0 -> HOLD, with the result registered that same edge. Iterative shift with amount > 0 -> SHIFT.
  - HOLD, with out_ready and no accept: -> IDLE.
  - SHIFT: shifts one bit per cycle and decrements its counter. When the counter reaches 0 it loads the result -> HOLD.
- Latency from accept to out_valid:
  - non-shift and barrel shift: 1 cycle.
  - iterative shift: 1 + amount cycles.
- Throughput: one operation per cycle with out_ready held high (non-iterative).
- While out_valid && !out_ready: out_result, out_flags and out_err stay stable.
- busy = (state==SHIFT); in_ready = 0 while busy.
- Operation results:
  - ADD: A+B. C = carry out. V = signed overflow.
  - SUB: A-B. C = 1 when A >= B unsigned (no borrow). V = signed overflow.
  - AND, OR, XOR, NOT (~A): C = 0, V = 0.
  - LSL and ASL: A shifted left, zero fill.
  - LSR: zero fill from the left. ASR: sign fill from the left.
  - All shifts: C = last bit shifted out (0 when amount = 0).
  - V = 0 for every op except ASL, where V = result MSB XOR A MSB.
  - N = result MSB; Z = (result == 0), for all ops.
- Illegal opcode: result 0, out_err = 1, flags {0,1,0,0}, latency 1.
- Operands are captured at accept. Input changes after accept have no effect.
- Reset mid-operation: in-flight op is dropped; out_valid and busy go to 0 asynchronously.

Optional Feature:
- Macro: ALU_EXEC_OPCOUNT_EN.
- When defined:
  - Adds output op_count, 16 bits: increments on every result handshake (out_valid && out_ready) and wraps at 0xFFFF -> 0.
  - Adds output err_count, 8 bits: counts results with out_err = 1 and saturates at 0xFF.
  - Both reset to 0.
- When undefined: neither port exists and no counter logic is present.

Decomposition:
- Package alu_exec_pkg:
  - opcode enum alu_op_e (10 legal codes).
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - state enum exec_state_e.
- Sub-module alu_shift_unit: barrel or iterative shift datapath selected by SHIFT_ITER. Produces the shifted value and the last shifted-out bit.

Test Plan (WIDTH=8):
- ADD A=0x7F, B=0x01, out_ready=1 -> 1 cycle after accept: result 0x80, flags N=1 Z=0 C=0 V=1, err=0.
- SUB A=0x05, B=0x05 -> result 0x00, flags N=0 Z=1 C=1 V=0. Then SUB A=0x03, B=0x05 -> 0xFE, N=1 C=0.
- SHIFT_ITER=1, ASR A=0x90, B=3 -> busy=1 and in_ready=0 for 3 cycles; out_valid 4 cycles after accept; result 0xF2, N=1 C=0. Repeat with B=0 -> 0x90 after 1 cycle, C=0.
- Backpressure: XOR 0xAA^0x0F held with out_ready=0 for 3 cycles -> 0xA5 stable and in_ready=0. Then out_ready=1 with in_valid=1 (AND 0xF0&0x3C) -> next op accepted that same cycle, 0x30 presented the following cycle.
- Illegal op 4'hC, A=0xFF -> result 0x00, err=1, flags {0,1,0,0}. With ALU_EXEC_OPCOUNT_EN: err_count=1 and op_count=1 after the handshake.
- Assert rst on the 2nd cycle of an iterative LSL A=0x01, B=5 -> out_valid=0 and busy=0 immediately. After release, ADD 0x01+0x01 -> 0x02 with normal 1-cycle latency.
